// File: rtl/im_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package im_loader_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 13;
  // Opcode field width; it is also the number of payload bits in the high byte.
  localparam int unsigned OPC_W   = INSTR_W - 8;
  localparam logic [7:0]  MAGIC   = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StCount,
    StHi,
    StLo,
    StWrite,
    StDone,
    StErr
  } ld_state_e;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream, instruction-memory write port and CPU control signals of the loader.
interface im_loader_if;

  logic                                   start;
  logic                                   byte_valid;
  logic [7:0]                             byte_data;
  logic                                   byte_ready;
  logic                                   im_we;
  logic [im_loader_pkg::ADDR_W-1:0]       im_addr;
  logic [im_loader_pkg::INSTR_W-1:0]      im_wdata;
  logic                                   cpu_hold;
  logic                                   done;
  logic                                   err;

  // The loader itself: consumes the stream, drives the memory and the CPU hold.
  modport master (
    input  start, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
  );

  // The surrounding system: byte source, instruction memory and CPU core.
  modport slave (
    output start, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_hold, done, err
  );

endinterface

// File: rtl/im_loader.sv
// Loads a counted, sync-prefixed byte stream into instruction memory as 13-bit words
// while holding the CPU stalled.
module im_loader
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  im_loader_if.master bus
);

  ld_state_e           state_q;
  logic                im_we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [INSTR_W-1:0]  wdata_q;
  logic                hold_q;
  logic                done_q;
  logic                err_q;
  // One bit wider than the address so that a count byte of 0 can mean 2^ADDR_W words.
  logic [ADDR_W:0]     rem_q;

  logic                byte_ready;
  logic                xfer;

  // Ready is decoded straight from the state so WRITE/DONE/ERR never accept a byte.
  always_comb begin
    byte_ready = 1'b0;
    unique case (state_q)
      StSync, StCount, StHi, StLo: byte_ready = 1'b1;
      default:                     byte_ready = 1'b0;
    endcase
  end

  assign xfer = bus.byte_valid & byte_ready;

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      im_we_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StSync;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        StSync: begin
          if (xfer) begin
            if (bus.byte_data == MAGIC) begin
              state_q <= StCount;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
        StCount: begin
          if (xfer) begin
            if (bus.byte_data == 8'h00) begin
              rem_q <= {1'b1, {ADDR_W{1'b0}}};
            end else begin
              rem_q <= {1'b0, bus.byte_data};
            end
            addr_q  <= '0;
            state_q <= StHi;
          end
        end
        StHi: begin
          if (xfer) begin
            // Bits above the instruction width must be zero, otherwise the stream is corrupt.
            if (bus.byte_data[7:OPC_W] != '0) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              wdata_q[INSTR_W-1:8] <= bus.byte_data[OPC_W-1:0];
              state_q              <= StLo;
            end
          end
        end
        StLo: begin
          if (xfer) begin
            wdata_q[7:0] <= bus.byte_data;
            im_we_q      <= 1'b1;
            state_q      <= StWrite;
          end
        end
        StWrite: begin
          im_we_q <= 1'b0;
          if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            rem_q   <= rem_q - (ADDR_W + 1)'(1);
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= StHi;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          hold_q  <= 1'b0;
          state_q <= StIdle;
        end
        StErr: begin
          if (bus.start) begin
            err_q   <= 1'b0;
            state_q <= StSync;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.im_we      = im_we_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writes program words into the writable instruction memory that the CPU core fetches from; it is the write side of the instruction-fetch path.
- Receives a byte stream over a valid/ready handshake from a host-side source and assembles 13-bit instruction words (5-bit opcode field, 8-bit immediate/control field).
- Issues one write per word at incrementing addresses.
- Holds the CPU (PC and registers) stalled while loading, then releases it.

Parameters:
- ADDR_W, 8, instruction memory address width (PC width).
- INSTR_W, 13, instruction word width; the high byte carries bits INSTR_W-1:8.
- MAGIC, 8'hA5, sync byte required at the start of every load.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled request to begin a load; honoured only in IDLE or ERR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- im_we  out  1  instruction memory write enable, one-cycle pulse per word.
- im_addr  out  ADDR_W  write address.
- im_wdata  out  INSTR_W  write data.
- cpu_hold  out  1  high while loading or in error; the CPU must not advance the PC.
- done  out  1  one-cycle pulse when a load completes successfully.
- err  out  1  sticky error flag.

Behaviour:
- Reset values (asynchronous, rst_n=0): state IDLE, byte_ready 0, im_we 0, im_addr 0, im_wdata 0, cpu_hold 0, done 0, err 0, remaining counter 0.
- A byte transfer occurs on a rising edge where byte_valid=1 and byte_ready=1. byte_ready is a pure decode of the state register: 1 only in SYNC, COUNT, HI and LO.
- All other outputs are registered.
- States and transitions:
  - IDLE: start=1 -> SYNC; cpu_hold:=1, err:=0.
  - SYNC: on transfer, byte==MAGIC -> COUNT, otherwise -> ERR.
  - COUNT: on transfer, remaining:=byte; byte 0 means 2^ADDR_W words (remaining counter is ADDR_W+1 bits). im_addr:=0 -> HI.
  - HI: on transfer, if byte[7:INSTR_W-8] != 0 -> ERR. Otherwise latch byte[INSTR_W-9:0] into im_wdata[INSTR_W-1:8] -> LO.
  - LO: on transfer, latch byte into im_wdata[7:0] -> WRITE.
  - WRITE: im_we=1 for exactly this cycle with the stable im_addr and im_wdata.
    - remaining==1 -> DONE.
    - Otherwise remaining-1, im_addr+1 -> HI.
  - DONE: done=1 for one cycle, cpu_hold:=0 -> IDLE.
  - ERR: err=1 and cpu_hold=1 persist, byte_ready=0. start=1 -> SYNC with err:=0.
- Latency:
  - First word write: earliest 4 cycles after the SYNC transfer.
  - Steady state: 3 cycles per word with back-to-back valid.
  - Full load: 2 + 3N + 1 cycles minimum.
- start is ignored in SYNC, COUNT, HI, LO, WRITE and DONE.
- byte_valid gaps stall the FSM in place with no timeout. byte_data is ignored when there is no transfer.
- Address wrap: N=256 writes addresses 0..255 in order. im_addr never wraps within one load. im_addr returns to 0 only at the next COUNT.
- Reset mid-load: returns to IDLE immediately, cpu_hold 0. Words already written remain in memory, and no partial write is issued.
- im_we and byte_ready are never high in the same cycle.

Decomposition:
- Shared package holds:
  - MAGIC.
  - INSTR_W, ADDR_W.
  - Opcode field width (5).
  - Loader state encoding: IDLE, SYNC, COUNT, HI, LO, WRITE, DONE, ERR.
- No sub-module: a single FSM with an address counter and remaining counter; word assembly is two register slices.
- Integration: im_loader sits beside the CPU core. cpu_hold gates the PC and register loads, and im_* drives the write port of the instruction memory.

Test Plan:
- Load N=2 with words 13'h0A55 then 13'h1F00, bytes A5,02,0A,55,1F,00 back-to-back -> im_we pulses at addr 0 data 0A55 and addr 1 data 1F00. done pulses once; cpu_hold high from start through the DONE cycle, 0 afterwards.
- Bad sync: start, then byte 3C -> ERR, err=1, cpu_hold=1, no im_we. A new start followed by A5,01,00,07 -> err clears, single write addr 0 data 0007, done.
- Bad high byte: A5,01,20 -> ERR after the HI transfer, no im_we, byte_ready stays 0 while byte_valid is held high.
- N=0 (256 words), with random byte_valid gaps -> exactly 256 writes, addresses 0..255 in order, no write to addr 0 after 255, done once.
- Reset mid-load: assert rst_n=0 after the 2nd word's HI byte -> all outputs at reset values immediately. Writes to addr 0 only; no further im_we until a new start.
- start pulsed during LO and again during WRITE -> no effect; the load completes normally.
